// File: rtl/nmr_scan_sequencer.sv
// -----------------------------------------------------------------------------
// nmr_scan_sequencer
// Multi-scan controller for the NMR pulse program. One accepted RUN request
// produces NUM_SCANS back-to-back CPMG scans. For each scan it issues a
// one-cycle start pulse, follows the pulse program busy flag until the scan
// ends, then waits SCAN_DELAY recovery cycles. The phase-cycle select toggles
// per scan when enabled.
//
// Ports
//   i_clk           system clock, rising edge
//   i_reset_n       synchronous active-low reset
//   i_run           one-cycle series request, honoured only when idle
//   i_abort         stop the series (beats i_run in the same cycle)
//   i_num_scans     scans per series, latched on accepted run
//   i_scan_delay    recovery cycles between scans, latched on accepted run
//   i_phase_cyc_en  per-scan phase alternation enable, latched on accepted run
//   i_pp_fsmstat    pulse program busy (1 = scan in progress)
//   o_pp_start      one-cycle start pulse to the pulse program
//   o_pp_phase_cyc  phase-cycle select, stable for the whole scan
//   o_busy          sequencer not idle
//   o_done          one-cycle pulse when the series completes
//   o_err           sticky: pulse program never acknowledged a start
//   o_scan_cnt      completed scans in the current/last series
// -----------------------------------------------------------------------------
module nmr_scan_sequencer #(
    parameter int DATABUS_WIDTH = 32,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_run,
    input  logic                     i_abort,
    input  logic [DATABUS_WIDTH-1:0] i_num_scans,
    input  logic [DATABUS_WIDTH-1:0] i_scan_delay,
    input  logic                     i_phase_cyc_en,
    input  logic                     i_pp_fsmstat,
    output logic                     o_pp_start,
    output logic                     o_pp_phase_cyc,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [DATABUS_WIDTH-1:0] o_scan_cnt
);

    localparam int DW   = DATABUS_WIDTH;
    localparam int WD_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    // The watchdog starts at zero in the first WAIT_ACK cycle (one cycle after
    // the start pulse), so the last tolerated value is ACK_TIMEOUT-2; this puts
    // ERR exactly ACK_TIMEOUT cycles after the start pulse.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 2);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    localparam logic [DW-1:0]   CNT_ONE = DW'(1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_WAIT_END = 3'd3;
    localparam logic [2:0] S_DELAY    = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;

    logic [2:0]      r_state;
    logic [DW-1:0]   r_num_scans;
    logic [DW-1:0]   r_scan_delay;
    logic            r_phase_en;
    logic [DW-1:0]   r_scan_cnt;
    logic [DW-1:0]   r_dly_cnt;
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_pp_start;
    logic            r_phase;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic [2:0]      w_state_nxt;
    logic [DW-1:0]   w_cnt_nxt;
    logic [DW-1:0]   w_cnt_inc;
    logic [DW-1:0]   w_dly_nxt;
    logic [WD_W-1:0] w_wd_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;
    logic            w_accept;

    // Saturating scan-count increment: never passes the latched scan total
    always_comb begin
        if (r_scan_cnt == r_num_scans) begin
            w_cnt_inc = r_scan_cnt;
        end else begin
            w_cnt_inc = r_scan_cnt + CNT_ONE;
        end
    end

    // Next-state, counter and pulse decisions for the sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_scan_cnt;
        w_dly_nxt   = r_dly_cnt;
        w_wd_nxt    = r_wd_cnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run && !i_abort) begin
                    w_accept  = 1'b1;
                    w_err_nxt = 1'b0;
                    w_cnt_nxt = '0;
                    // An empty series completes immediately without a scan
                    if (i_num_scans == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_START;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                w_wd_nxt = '0;
                if (i_abort) begin
                    w_state_nxt = i_pp_fsmstat ? S_DRAIN : S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (i_abort) begin
                    w_state_nxt = i_pp_fsmstat ? S_DRAIN : S_IDLE;
                end else if (i_pp_fsmstat) begin
                    w_state_nxt = S_WAIT_END;
                end else if (r_wd_cnt == WD_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wd_nxt = r_wd_cnt + WD_ONE;
                end
            end
            S_WAIT_END: begin
                if (i_abort) begin
                    w_state_nxt = S_DRAIN;
                end else if (!i_pp_fsmstat) begin
                    w_cnt_nxt = w_cnt_inc;
                    w_dly_nxt = '0;
                    if (r_scan_delay != '0) begin
                        w_state_nxt = S_DELAY;
                    end else if (w_cnt_inc == r_num_scans) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_START;
                    end
                end else begin
                    w_state_nxt = S_WAIT_END;
                end
            end
            S_DELAY: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_dly_cnt == (r_scan_delay - CNT_ONE)) begin
                    if (r_scan_cnt == r_num_scans) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_START;
                    end
                end else begin
                    w_dly_nxt = r_dly_cnt + CNT_ONE;
                end
            end
            S_DRAIN: begin
                if (!i_pp_fsmstat) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters, latched parameters and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_num_scans  <= '0;
            r_scan_delay <= '0;
            r_phase_en   <= 1'b0;
            r_scan_cnt   <= '0;
            r_dly_cnt    <= '0;
            r_wd_cnt     <= '0;
            r_pp_start   <= 1'b0;
            r_phase      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_scan_cnt <= w_cnt_nxt;
            r_dly_cnt  <= w_dly_nxt;
            r_wd_cnt   <= w_wd_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_pp_start <= (w_state_nxt == S_START);
            r_busy     <= (w_state_nxt != S_IDLE);
            if (w_accept) begin
                r_num_scans  <= i_num_scans;
                r_scan_delay <= i_scan_delay;
                r_phase_en   <= i_phase_cyc_en;
            end else begin
                r_num_scans  <= r_num_scans;
                r_scan_delay <= r_scan_delay;
                r_phase_en   <= r_phase_en;
            end
            // Scan index equals the completed-scan count at the moment a new
            // scan starts; on the first scan the enable is not yet latched but
            // the index is zero, so phase 0 results either way.
            if (w_state_nxt == S_START) begin
                r_phase <= r_phase_en & w_cnt_nxt[0];
            end else begin
                r_phase <= r_phase;
            end
        end
    end

    assign o_pp_start     = r_pp_start;
    assign o_pp_phase_cyc = r_phase;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_scan_cnt     = r_scan_cnt;

endmodule

// File: tb/tb_nmr_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nmr_scan_sequencer
// Scoreboard bench: each issued series pushes its expected start/done/error
// events (cycle, phase, count) computed from the timing rules; a monitor pops
// and compares whenever the sequencer presents one. A small pulse-program
// model answers each start pulse with a busy window of configurable latency
// and length.
// -----------------------------------------------------------------------------
module tb_nmr_scan_sequencer;

    localparam int DW = 32;
    localparam int AT = 16;

    typedef struct {
        int     kind;   // 0 = start pulse, 1 = done, 2 = error rise
        longint cyc;
        longint val;    // phase for start, scan count for done
    } ev_t;

    logic          clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_run = 1'b0;
    logic          i_abort = 1'b0;
    logic [DW-1:0] i_num_scans = '0;
    logic [DW-1:0] i_scan_delay = '0;
    logic          i_phase_cyc_en = 1'b0;
    logic          i_pp_fsmstat = 1'b0;
    logic          o_pp_start;
    logic          o_pp_phase_cyc;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [DW-1:0] o_scan_cnt;

    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    ev_t    exp_q[$];
    longint sched_s[8];
    longint sched_f[8];

    // Pulse-program model settings and its current busy window
    int     pp_lat = 2;
    int     pp_len = 10;
    bit     pp_noack = 1'b0;
    longint hi_start = -1;
    longint hi_end = -1;
    bit     prev_start = 1'b0;
    bit     prev_err = 1'b0;

    nmr_scan_sequencer #(.DATABUS_WIDTH(DW), .ACK_TIMEOUT(AT)) dut (
        .i_clk          (clk),
        .i_reset_n      (i_reset_n),
        .i_run          (i_run),
        .i_abort        (i_abort),
        .i_num_scans    (i_num_scans),
        .i_scan_delay   (i_scan_delay),
        .i_phase_cyc_en (i_phase_cyc_en),
        .i_pp_fsmstat   (i_pp_fsmstat),
        .o_pp_start     (o_pp_start),
        .o_pp_phase_cyc (o_pp_phase_cyc),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_scan_cnt     (o_scan_cnt)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic pop_check(input int kind, input longint val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            chk("event_value", val, e.val);
        end
    endtask

    // Pulse program: busy window opens pp_lat cycles after a start pulse
    always @(negedge clk) begin
        if (o_pp_start && !pp_noack) begin
            hi_start = cyc + pp_lat;
            hi_end   = cyc + pp_lat + pp_len;
        end
    end

    always @(posedge clk) begin
        #1;
        i_pp_fsmstat = (cyc >= hi_start) && (cyc < hi_end);
    end

    // Monitor: compare every presented event against the scoreboard
    always @(negedge clk) begin
        if (i_reset_n) begin
            if (o_pp_start) begin
                chk("pp_start_back_to_back", prev_start, 0);
                chk("pp_start_while_fsmstat", i_pp_fsmstat, 0);
                pop_check(0, o_pp_phase_cyc);
            end
            if (o_done) pop_check(1, o_scan_cnt);
            if (o_err && !prev_err) pop_check(2, 0);
        end
        prev_start = o_pp_start;
        prev_err   = o_err;
    end

    task automatic goto(input longint c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ev(input int kind, input longint c, input longint v);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Issue RUN and record the expected timeline. Only scans with index < cut
    // get start events; the done event is expected only when nothing is cut.
    task automatic issue_series(input int n, input int d, input int en, input int l,
                                input int h, input bit noack, input int cut);
        longint s;
        longint f;
        pp_lat = l;
        pp_len = h;
        pp_noack = noack;
        i_num_scans = n;
        i_scan_delay = d;
        i_phase_cyc_en = en[0];
        i_run = 1'b1;
        s = cyc + 1;
        if (n == 0) begin
            push_ev(1, s, 0);
        end else if (noack) begin
            push_ev(0, s, 0);
            push_ev(2, s + AT, 0);
        end else begin
            for (int k = 0; k < n; k++) begin
                if (k < cut) push_ev(0, s, en & (k % 2));
                f = s + l + h;
                sched_s[k] = s;
                sched_f[k] = f;
                if (k == n - 1) begin
                    if (cut >= n) push_ev(1, f + 1 + d, n);
                end else begin
                    s = f + 1 + d;
                end
            end
        end
        @(posedge clk);
        #1;
        i_run = 1'b0;
        // Parameters must have been latched; scramble the live inputs
        i_num_scans = $urandom;
        i_scan_delay = $urandom;
        i_phase_cyc_en = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_empty(input int budget);
        longint lim;
        lim = cyc + budget;
        while (exp_q.size() != 0 && cyc < lim) begin
            @(posedge clk);
            #1;
        end
        chk("expected_events_outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int n, d, en, l, h;
        // Reset state
        goto(3);
        chk("reset_pp_start", o_pp_start, 0);
        chk("reset_phase", o_pp_phase_cyc, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_err", o_err, 0);
        chk("reset_scan_cnt", o_scan_cnt, 0);
        i_reset_n = 1'b1;
        goto(5);

        // Three scans with delay, phase alternation, and a RUN while busy
        issue_series(3, 10, 1, 2, 50, 1'b0, 3);
        chk("t1_busy", o_busy, 1);
        goto(sched_s[0] + 1);
        i_run = 1'b1;
        i_num_scans = 7;
        @(posedge clk);
        #1;
        i_run = 1'b0;
        wait_empty(400);
        chk("t1_scan_cnt", o_scan_cnt, 3);
        chk("t1_busy_end", o_busy, 0);
        goto(cyc + 3);

        // Empty series
        issue_series(0, 5, 1, 2, 10, 1'b0, 1);
        chk("t2_busy", o_busy, 0);
        wait_empty(5);
        chk("t2_busy_after", o_busy, 0);
        chk("t2_scan_cnt", o_scan_cnt, 0);

        // Zero delay between scans
        issue_series(2, 0, 1, 3, 20, 1'b0, 2);
        wait_empty(200);
        chk("t3_scan_cnt", o_scan_cnt, 2);

        // Missing acknowledge
        issue_series(2, 3, 0, 2, 10, 1'b1, 1);
        wait_empty(AT + 10);
        goto(cyc + 20);
        chk("t4_err", o_err, 1);
        chk("t4_busy", o_busy, 0);
        chk("t4_scan_cnt", o_scan_cnt, 0);
        issue_series(0, 0, 0, 2, 10, 1'b0, 1);
        chk("t4_err_cleared", o_err, 0);
        wait_empty(5);

        // Abort during the second scan
        issue_series(3, 4, 1, 3, 30, 1'b0, 2);
        goto(sched_s[1] + 8);
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        goto(sched_f[1]);
        chk("t5_busy_drain", o_busy, 1);
        goto(sched_f[1] + 1);
        chk("t5_busy_idle", o_busy, 0);
        chk("t5_scan_cnt", o_scan_cnt, 1);
        goto(cyc + 30);
        wait_empty(1);
        i_num_scans = 2;
        i_run = 1'b1;
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        i_run = 1'b0;
        i_abort = 1'b0;
        goto(cyc + 10);
        chk("t5_run_abort_busy", o_busy, 0);
        chk("t5_run_abort_cnt", o_scan_cnt, 1);
        wait_empty(1);

        // Reset in the middle of the delay after the second scan
        issue_series(3, 20, 1, 2, 10, 1'b0, 2);
        goto(sched_f[1] + 5);
        i_reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_pp_start", o_pp_start, 0);
        chk("t6_phase", o_pp_phase_cyc, 0);
        chk("t6_busy", o_busy, 0);
        chk("t6_done", o_done, 0);
        chk("t6_err", o_err, 0);
        chk("t6_scan_cnt", o_scan_cnt, 0);
        i_reset_n = 1'b1;
        goto(cyc + 40);
        chk("t6_busy_after", o_busy, 0);
        wait_empty(1);

        // Randomized series
        for (int it = 0; it < 8; it++) begin
            n  = $urandom_range(1, 4);
            d  = $urandom_range(0, 12);
            en = $urandom_range(0, 1);
            l  = $urandom_range(1, AT - 1);
            h  = $urandom_range(1, 40);
            issue_series(n, d, en, l, h, 1'b0, n);
            chk("rnd_busy", o_busy, 1);
            wait_empty(n * (l + h + d + 2) + 20);
            chk("rnd_scan_cnt", o_scan_cnt, n);
            chk("rnd_busy_end", o_busy, 0);
            goto(cyc + $urandom_range(1, 5));
        end

        goto(cyc + 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
